aes_result_uart_tx: RTL and testbench
=====================================

Name: aes_result_uart_tx

Overview:
- Readout end of the power-analysis AES harness: captures the 128-bit ciphertext when the AES core finishes and serialises it off-chip over a UART 8N1 TX line.
- Sits beside aes_core, fed by its data_o/busy_o, and drives a single FPGA pin.
- Transmits one optional header byte, then 16 ciphertext bytes, MSB byte first. This lets a host pair each power trace with its ciphertext.

Parameters:
- CLKS_PER_BIT, 104, ICE_CLK cycles per UART bit (12 MHz / 115200). Must be >= 2.
- SEND_HEADER, 1, 1 = prepend the HEADER byte to each frame; 0 = ciphertext bytes only.
- HEADER, 8'hA5, sync byte value.

Ports:
- ICE_CLK  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low; clock ICE_CLK.
- aes_busy_i  input  1  AES core busy_o; a 1->0 transition marks a valid result.
- aes_data_i  input  128  AES core data_o; sampled on the capture edge.
- uart_tx_o  output  1  serial line; idle high.
- tx_busy_o  output  1  high while a frame is in flight.
- frame_done_o  output  1  one-cycle pulse after the last stop bit completes.
- drop_count_o  output  8  results lost because a frame was already in flight; saturates at 255.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - uart_tx_o=1, tx_busy_o=0, frame_done_o=0, drop_count_o=0.
  - Internal busy_q=0; state IDLE.
  - Reset mid-frame abandons the frame. The line returns high on that edge and no partial bytes resume afterwards.
- Edge detect:
  - busy_q <= aes_busy_i every cycle.
  - Capture event = busy_q==1 && aes_busy_i==0.
  - Busy held low straight out of reset produces no event.
- States: IDLE, START, DATA, STOP.
  - A bit counter (0..7), a byte counter (0..NBYTES-1) and a baud counter (0..CLKS_PER_BIT-1) support the states.
  - NBYTES = 17 if SEND_HEADER=1, else 16.
- IDLE:
  - uart_tx_o=1, tx_busy_o=0.
  - On a capture event: load the 136-bit (or 128-bit) shift buffer {HEADER, aes_data_i}, go to START, reset the baud counter, and set uart_tx_o=0 and tx_busy_o=1 on the same edge.
  - The start bit therefore begins 1 cycle after busy falls.
- START: hold uart_tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit 0.
- DATA:
  - Output the current byte LSB first, each bit for CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP:
  - uart_tx_o=1 for CLKS_PER_BIT cycles.
  - If more bytes remain, advance to the next byte (buffer shifts 8 bits toward MSB) and go directly to START with no idle gap.
  - Otherwise go to IDLE and pulse frame_done_o for the first IDLE cycle.
- Byte order and length:
  - Header first, then aes_data_i[127:120], ..., aes_data_i[7:0].
  - Frame length is exactly NBYTES*10*CLKS_PER_BIT cycles, from the start-bit edge to the IDLE entry edge.
- Drops:
  - A capture event in any non-IDLE state, including the final STOP cycle, increments drop_count_o (saturating) and is otherwise ignored.
  - The in-flight frame and the buffer are not disturbed.
  - drop_count_o clears only on reset.
- aes_data_i may change freely after the capture edge; only the buffered copy is transmitted.

Test Plan:
1. Reset, then aes_busy_i held 0 for 1000 cycles -> uart_tx_o stays 1, tx_busy_o=0, drop_count_o=0.
2. CLKS_PER_BIT=4, SEND_HEADER=1; aes_data_i=128'h69c4e0d86a7b0430d8cdb78070b4c55a; busy 1->0 -> start bit begins 1 cycle later.
   - The line decodes as A5,69,C4,E0,...,5A.
   - The first header data bits are 1,0,1,0,0,1,0,1.
   - frame_done_o pulses once, 680 cycles after the start edge.
3. Second busy falling edge mid-frame (at cycle 300) -> frame bytes unchanged, drop_count_o=1.
   - 300 further mid-frame edges -> drop_count_o saturates at 255.
4. Falling edge on the final STOP cycle -> counted as a drop, no new frame.
   - Falling edge on the first IDLE cycle (coincident with the frame_done_o pulse) -> new frame starts.
5. resetn=0 during DATA of byte 5 -> uart_tx_o=1 on that edge, tx_busy_o=0, drop_count_o=0, and no further transitions until the next capture event.
6. SEND_HEADER=0, CLKS_PER_BIT=2, aes_data_i=128'h00112233445566778899aabbccddeeff -> bytes 00,11,...,FF and a frame length of 320 cycles.

Source files
------------

// File: rtl/aes_result_uart_tx.sv
// ---------------------------------------------------------------------------
// aes_result_uart_tx
//
// Readout end of the power-analysis AES harness. When the AES core drops its
// busy flag, the 128-bit ciphertext is captured into a shift buffer. The
// buffer is then sent as UART 8N1 on a single pin: an optional sync header
// first, then the ciphertext, MSB byte first and LSB bit first within each
// byte. A host can then pair each power trace with its ciphertext.
//
// Parameters:
//   CLKS_PER_BIT  ICE_CLK cycles per UART bit (>= 2)
//   SEND_HEADER   1 = prepend HEADER to each frame, 0 = ciphertext only
//   HEADER        sync byte value
//
// Ports:
//   ICE_CLK       system clock
//   resetn        synchronous active-low reset
//   aes_busy_i    AES core busy; a 1->0 transition marks a valid result
//   aes_data_i    AES core result, sampled on the capture edge
//   uart_tx_o     serial line, idle high
//   tx_busy_o     high while a frame is in flight
//   frame_done_o  one-cycle pulse in the first idle cycle after a frame
//   drop_count_o  results lost to an in-flight frame, saturates at 255
// ---------------------------------------------------------------------------
module aes_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter bit          SEND_HEADER  = 1'b1,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic         ICE_CLK,
  input  logic         resetn,
  input  logic         aes_busy_i,
  input  logic [127:0] aes_data_i,
  output logic         uart_tx_o,
  output logic         tx_busy_o,
  output logic         frame_done_o,
  output logic [7:0]   drop_count_o
);

  localparam int unsigned NBYTES = SEND_HEADER ? 17 : 16;
  localparam int unsigned NBITS  = NBYTES * 8;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        BYTE_LAST = 5'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q,   state_d;
  logic              busy_q;
  logic [BAUD_W-1:0] baud_q,    baud_d;
  logic [2:0]        bit_q,     bit_d;
  logic [4:0]        byte_q,    byte_d;
  logic [NBITS-1:0]  buf_q,     buf_d;
  logic              tx_q,      tx_d;
  logic              tx_busy_q, tx_busy_d;
  logic              done_q,    done_d;
  logic [7:0]        drop_q,    drop_d;

  logic [NBITS-1:0]  load_word;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_nxt;
  logic              capture;
  logic              baud_done;

  // Frame image loaded on capture; the byte on air is always the top byte.
  if (SEND_HEADER) begin : g_hdr
    assign load_word = {HEADER, aes_data_i};
  end else begin : g_nohdr
    assign load_word = aes_data_i;
  end

  assign cur_byte  = buf_q[NBITS-1 -: 8];
  assign bit_nxt   = bit_q + 3'd1;
  assign capture   = busy_q & ~aes_busy_i;
  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    buf_d     = buf_q;
    tx_d      = tx_q;
    tx_busy_d = tx_busy_q;
    done_d    = 1'b0;
    drop_d    = drop_q;

    // A result arriving while any frame is on air (final STOP cycle included)
    // is only counted; the frame and its buffer stay untouched.
    if (capture && (state_q != IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (capture) begin
          buf_d     = load_word;
          byte_d    = '0;
          bit_d     = '0;
          baud_d    = '0;
          state_d   = START;
          tx_d      = 1'b0;
          tx_busy_d = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d   = IDLE;
            tx_busy_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            // Back-to-back bytes: next start bit follows the stop bit directly.
            byte_d  = byte_q + 5'd1;
            buf_d   = buf_q << 8;
            state_d = START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ICE_CLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= aes_busy_i;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  // NOTE: the shift buffer has no reset; it is always loaded on capture
  // before any of its bits reach the line.
  always_ff @(posedge ICE_CLK) begin
    buf_q <= buf_d;
  end

  assign uart_tx_o    = tx_q;
  assign tx_busy_o    = tx_busy_q;
  assign frame_done_o = done_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_aes_result_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_aes_result_uart_tx
//
// Two instances: dut_a (CLKS_PER_BIT=4, header A5) and dut_b (CLKS_PER_BIT=2,
// no header). Expected bytes are queued when a capture is triggered and
// popped by a cycle-exact UART decoder. Outputs are sampled on the falling
// clock edge; cyc counts rising edges.
// ---------------------------------------------------------------------------
module tb_aes_result_uart_tx;

  logic         ICE_CLK = 1'b0;
  logic         resetn  = 1'b0;
  logic         busy_a  = 1'b0;
  logic         busy_b  = 1'b0;
  logic [127:0] data_a  = '0;
  logic [127:0] data_b  = '0;
  logic         tx_a, tx_b, tbusy_a, tbusy_b, done_a, done_b;
  logic [7:0]   drop_a, drop_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] exp_q[$];

  always #5 ICE_CLK = ~ICE_CLK;
  always @(posedge ICE_CLK) cyc <= cyc + 1;

  aes_result_uart_tx #(.CLKS_PER_BIT(4), .SEND_HEADER(1'b1), .HEADER(8'hA5)) dut_a (
    .ICE_CLK(ICE_CLK), .resetn(resetn), .aes_busy_i(busy_a), .aes_data_i(data_a),
    .uart_tx_o(tx_a), .tx_busy_o(tbusy_a), .frame_done_o(done_a), .drop_count_o(drop_a)
  );

  aes_result_uart_tx #(.CLKS_PER_BIT(2), .SEND_HEADER(1'b0), .HEADER(8'hA5)) dut_b (
    .ICE_CLK(ICE_CLK), .resetn(resetn), .aes_busy_i(busy_b), .aes_data_i(data_b),
    .uart_tx_o(tx_b), .tx_busy_o(tbusy_b), .frame_done_o(done_b), .drop_count_o(drop_b)
  );

  function automatic logic line_of(input int sel);
    return (sel != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic tbusy_of(input int sel);
    return (sel != 0) ? tbusy_b : tbusy_a;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel != 0) ? done_b : done_a;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance (on falling edges) until cyc reaches t.
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge ICE_CLK);
  endtask

  task automatic push_frame(input bit hdr, input logic [127:0] d);
    if (hdr) exp_q.push_back(8'hA5);
    for (int i = 15; i >= 0; i--) exp_q.push_back(d[i*8 +: 8]);
  endtask

  // Busy 1 -> 0 around a result; returns n0, the cycle index of the
  // rising edge that starts the start bit.
  task automatic trigger(input int sel, input logic [127:0] d, input bit push,
                         output int n0);
    @(negedge ICE_CLK);
    if (sel != 0) begin busy_b = 1'b1; data_b = d; end
    else          begin busy_a = 1'b1; data_a = d; end
    @(negedge ICE_CLK);
    if (sel != 0) busy_b = 1'b0; else busy_a = 1'b0;
    checks++;
    if (line_of(sel) !== 1'b1)
      $display("FAIL pre_start dut%0d: line=%b want 1", sel, line_of(sel));
    if (line_of(sel) !== 1'b1) errors++;
    @(negedge ICE_CLK);
    n0 = cyc;
    checks++;
    if (line_of(sel) !== 1'b0 || tbusy_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL start_latency dut%0d: line=%b busy=%b want 0/1",
               sel, line_of(sel), tbusy_of(sel));
    end
    // Input may change freely once captured.
    if (sel != 0) data_b = rnd128(); else data_a = rnd128();
    if (push) push_frame(sel == 0, d);
  endtask

  // Cycle-exact decoder: samples each bit mid-period, pops the scoreboard.
  task automatic receive(input int sel, input int cpb, input int nb, input int n0);
    int t;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] got;
      logic [7:0] exp;
      bit         framing_ok;
      framing_ok = 1'b1;
      got = '0;
      for (int pos = 0; pos < 10; pos++) begin
        wait_to(n0 + (b*10 + pos)*cpb + cpb/2);
        if (pos == 0)      framing_ok &= (line_of(sel) === 1'b0);
        else if (pos == 9) framing_ok &= (line_of(sel) === 1'b1);
        else               got[pos-1] = line_of(sel);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte dut%0d[%0d]: got=%h with empty scoreboard", sel, b, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp || !framing_ok) begin
          errors++;
          $display("FAIL byte dut%0d[%0d]: got=%h framing_ok=%0d want %h framing_ok=1",
                   sel, b, got, framing_ok, exp);
        end
      end
    end
    t = n0 + nb*10*cpb;
    wait_to(t - 1);
    checks++;
    if (done_of(sel) !== 1'b0 || tbusy_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL frame_len_early dut%0d: done=%b busy=%b want 0/1",
               sel, done_of(sel), tbusy_of(sel));
    end
    wait_to(t);
    checks++;
    if (done_of(sel) !== 1'b1 || tbusy_of(sel) !== 1'b0 || line_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL frame_done dut%0d: done=%b busy=%b line=%b want 1/0/1",
               sel, done_of(sel), tbusy_of(sel), line_of(sel));
    end
    wait_to(t + 1);
    checks++;
    if (done_of(sel) !== 1'b0) begin
      errors++;
      $display("FAIL done_width dut%0d: done=%b want 0", sel, done_of(sel));
    end
  endtask

  task automatic check_quiet(input int sel, input int n, input string name);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge ICE_CLK);
      if (line_of(sel) !== 1'b1 || tbusy_of(sel) !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d: line/busy left idle (last line=%b busy=%b) want 1/0",
               name, sel, line_of(sel), tbusy_of(sel));
    end
  endtask

  task automatic check_drop(input logic [7:0] want, input string name);
    checks++;
    if (drop_a !== want) begin
      errors++;
      $display("FAIL %s: drop_count=%0d want %0d", name, drop_a, want);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge ICE_CLK);
    checks++;
    if ({tx_a, tbusy_a, done_a, drop_a, tx_b, tbusy_b, done_b, drop_b} !==
        {3'b100, 8'd0, 3'b100, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: a=%b%b%b/%0d b=%b%b%b/%0d want 100/0 100/0",
               tx_a, tbusy_a, done_a, drop_a, tx_b, tbusy_b, done_b, drop_b);
    end
    resetn = 1'b1;
    check_quiet(0, 1000, "idle_after_reset");
    check_quiet(1, 1, "idle_after_reset");
    check_drop(8'd0, "drop_after_idle");
  endtask

  // Known vector, one drop mid-frame and one on the final STOP cycle.
  task automatic test_frame_and_drops();
    int n0;
    trigger(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, n0);
    fork
      receive(0, 4, 17, n0);
      begin
        wait_to(n0 + 300); busy_a = 1'b1;
        wait_to(n0 + 301); busy_a = 1'b0;
        wait_to(n0 + 303); check_drop(8'd1, "drop_mid_frame");
        wait_to(n0 + 678); busy_a = 1'b1;
        wait_to(n0 + 679); busy_a = 1'b0;
        wait_to(n0 + 682); check_drop(8'd2, "drop_final_stop");
      end
    join
    check_quiet(0, 40, "no_frame_after_stop_drop");
  endtask

  // Capture in the first IDLE cycle starts the next frame; returns its n0.
  task automatic test_back_to_back(output int n_next);
    int n0;
    logic [127:0] d3;
    d3 = rnd128();
    trigger(0, rnd128(), 1'b1, n0);
    fork
      receive(0, 4, 17, n0);
      begin
        wait_to(n0 + 679); busy_a = 1'b1;
        wait_to(n0 + 680); busy_a = 1'b0; data_a = d3;
        push_frame(1'b1, d3);
        wait_to(n0 + 681);
        checks++;
        if (tx_a !== 1'b0 || tbusy_a !== 1'b1) begin
          errors++;
          $display("FAIL restart_on_done: line=%b busy=%b want 0/1", tx_a, tbusy_a);
        end
        data_a = rnd128();
      end
    join
    n_next = n0 + 681;
    check_drop(8'd2, "drop_no_count_in_idle");
  endtask

  task automatic test_drop_saturate(input int n0);
    fork
      receive(0, 4, 17, n0);
      begin
        wait_to(n0 + 10);
        for (int i = 0; i < 300; i++) begin
          busy_a = 1'b1; data_a = rnd128();
          @(negedge ICE_CLK);
          busy_a = 1'b0;
          @(negedge ICE_CLK);
        end
        check_drop(8'd255, "drop_saturate");
      end
    join
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    // All-zero payload so the line is low in DATA at the reset point.
    trigger(0, 128'h0, 1'b0, n0);
    wait_to(n0 + (5*10 + 3)*4 + 1);
    checks++;
    if (tx_a !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_line: line=%b want 0", tx_a);
    end
    resetn = 1'b0;
    @(negedge ICE_CLK);
    checks++;
    if ({tx_a, tbusy_a, done_a, drop_a} !== {3'b100, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid_frame: line=%b busy=%b done=%b drop=%0d want 1/0/0/0",
               tx_a, tbusy_a, done_a, drop_a);
    end
    resetn = 1'b1;
    check_quiet(0, 200, "no_resume_after_reset");
    trigger(0, rnd128(), 1'b1, n0);
    receive(0, 4, 17, n0);
    check_drop(8'd0, "drop_after_reset_frame");
  endtask

  task automatic test_no_header();
    int n0;
    trigger(1, 128'h00112233445566778899aabbccddeeff, 1'b1, n0);
    receive(1, 2, 16, n0);
    check_quiet(1, 10, "idle_after_no_header");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n3;
    test_reset();
    test_frame_and_drops();
    test_back_to_back(n3);
    test_drop_saturate(n3);
    test_reset_mid_frame();
    test_no_header();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d bytes left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
